twiddle_lut: RTL and testbench

Read-only twiddle-factor table for a 16-point radix-2 FFT. Given an index k (0..15), it returns W16^k = cos(2πk/16) − j·sin(2πk/16) as two signed 16-bit fixed-point words. The outputs are registered. The block feeds the butterfly multipliers in the FFT datapath.

---
 rtl/twiddle_lut.sv | 127 ++++++++++++
 tb/tb_twiddle_lut.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/twiddle_lut.sv
// -----------------------------------------------------------------------------
// twiddle_lut
//
// Read-only twiddle-factor table for a 16-point radix-2 FFT. For index k it
// returns W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) as two signed Q2.14 words
// (1.0 = 0x4000). The lookup is purely combinational and the result is
// captured in the output registers, giving one cycle of latency and one new
// index per cycle.
//
// Ports
//   clk               in   1   system clock, rising-edge active
//   rst               in   1   asynchronous active-low reset; clears outputs
//   twiddle_num       in   4   twiddle index k, unsigned 0..15 (all legal)
//   twiddle_val_real  out  16  Re(W16^k), signed Q2.14, registered
//   twiddle_val_imag  out  16  Im(W16^k) = -sin(2*pi*k/16), signed Q2.14,
//                              registered
// -----------------------------------------------------------------------------
module twiddle_lut (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  twiddle_num,
  output logic [15:0] twiddle_val_real,
  output logic [15:0] twiddle_val_imag
);

  // Q2.14 magnitudes, round-to-nearest of value * 16384.
  localparam logic [15:0] POS_ONE  = 16'h4000;  //  1.0
  localparam logic [15:0] POS_C225 = 16'h3B21;  //  cos 22.5 deg
  localparam logic [15:0] POS_C450 = 16'h2D41;  //  cos 45 deg
  localparam logic [15:0] POS_C675 = 16'h187E;  //  cos 67.5 deg
  localparam logic [15:0] ZERO     = 16'h0000;
  localparam logic [15:0] NEG_ONE  = 16'hC000;  // -1.0
  localparam logic [15:0] NEG_C225 = 16'hC4DF;  // -cos 22.5 deg
  localparam logic [15:0] NEG_C450 = 16'hD2BF;  // -cos 45 deg
  localparam logic [15:0] NEG_C675 = 16'hE782;  // -cos 67.5 deg

  logic [15:0] real_s;
  logic [15:0] imag_s;

  // Full 16-entry table; the imaginary column carries the -sin sign already.
  always_comb begin
    real_s = ZERO;
    imag_s = ZERO;
    case (twiddle_num)
      4'd0: begin
        real_s = POS_ONE;
        imag_s = ZERO;
      end
      4'd1: begin
        real_s = POS_C225;
        imag_s = NEG_C675;
      end
      4'd2: begin
        real_s = POS_C450;
        imag_s = NEG_C450;
      end
      4'd3: begin
        real_s = POS_C675;
        imag_s = NEG_C225;
      end
      4'd4: begin
        real_s = ZERO;
        imag_s = NEG_ONE;
      end
      4'd5: begin
        real_s = NEG_C675;
        imag_s = NEG_C225;
      end
      4'd6: begin
        real_s = NEG_C450;
        imag_s = NEG_C450;
      end
      4'd7: begin
        real_s = NEG_C225;
        imag_s = NEG_C675;
      end
      4'd8: begin
        real_s = NEG_ONE;
        imag_s = ZERO;
      end
      4'd9: begin
        real_s = NEG_C225;
        imag_s = POS_C675;
      end
      4'd10: begin
        real_s = NEG_C450;
        imag_s = POS_C450;
      end
      4'd11: begin
        real_s = NEG_C675;
        imag_s = POS_C225;
      end
      4'd12: begin
        real_s = ZERO;
        imag_s = POS_ONE;
      end
      4'd13: begin
        real_s = POS_C675;
        imag_s = POS_C225;
      end
      4'd14: begin
        real_s = POS_C450;
        imag_s = POS_C450;
      end
      4'd15: begin
        real_s = POS_C225;
        imag_s = POS_C675;
      end
      default: begin
        real_s = ZERO;
        imag_s = ZERO;
      end
    endcase
  end

  // Output registers: both words load together so real/imag always pair up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      twiddle_val_real <= ZERO;
      twiddle_val_imag <= ZERO;
    end else begin
      twiddle_val_real <= real_s;
      twiddle_val_imag <= imag_s;
    end
  end

endmodule

// File: tb/tb_twiddle_lut.sv
// -----------------------------------------------------------------------------
// tb_twiddle_lut
//
// Directed self-checking bench for twiddle_lut. Expected values are the
// hand-written twiddle list; every comparison is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_twiddle_lut;

  logic        clk;
  logic        rst;
  logic [3:0]  twiddle_num;
  logic [15:0] twiddle_val_real;
  logic [15:0] twiddle_val_imag;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  localparam logic [15:0] EXP_RE [16] = '{
    16'h4000, 16'h3B21, 16'h2D41, 16'h187E,
    16'h0000, 16'hE782, 16'hD2BF, 16'hC4DF,
    16'hC000, 16'hC4DF, 16'hD2BF, 16'hE782,
    16'h0000, 16'h187E, 16'h2D41, 16'h3B21
  };
  localparam logic [15:0] EXP_IM [16] = '{
    16'h0000, 16'hE782, 16'hD2BF, 16'hC4DF,
    16'hC000, 16'hC4DF, 16'hD2BF, 16'hE782,
    16'h0000, 16'h187E, 16'h2D41, 16'h3B21,
    16'h4000, 16'h3B21, 16'h2D41, 16'h187E
  };

  twiddle_lut dut (
    .clk              (clk),
    .rst              (rst),
    .twiddle_num      (twiddle_num),
    .twiddle_val_real (twiddle_val_real),
    .twiddle_val_imag (twiddle_val_imag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check16(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input string tag, input logic [15:0] exp_re,
                            input logic [15:0] exp_im);
    check16({tag, ".re"}, twiddle_val_real, exp_re);
    check16({tag, ".im"}, twiddle_val_imag, exp_im);
  endtask

  // Magnitude within 2 LSB of 1.0: |re^2+im^2 - 16384^2| <= ~4*16384.
  task automatic check_power(input string tag);
    longint re;
    longint im;
    longint diff;
    re   = longint'($signed(twiddle_val_real));
    im   = longint'($signed(twiddle_val_imag));
    diff = re * re + im * im - 64'sd268435456;
    if (diff < 0) diff = -diff;
    cmp_cnt++;
    assert (diff <= 64'sd65540) else begin
      mis_cnt++;
      $error("FAIL %s: observed |err| %0d expected <= 65540", tag, diff);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int quad [4];
    quad = '{0, 4, 8, 12};

    // Reset held low with index 5 and the clock running.
    rst         = 1'b0;
    twiddle_num = 4'd5;
    #1;
    check_pair("reset_t0", 16'h0000, 16'h0000);
    step();
    step();
    check_pair("reset_held", 16'h0000, 16'h0000);

    // Release between edges; first edge loads k=5.
    #2;
    rst = 1'b1;
    step();
    check_pair("reset_release_k5", 16'hE782, 16'hC4DF);

    // Quadrant points, each held for several cycles.
    for (int q = 0; q < 4; q++) begin
      logic [15:0] prev_re;
      logic [15:0] prev_im;
      prev_re     = (q == 0) ? 16'hE782 : EXP_RE[quad[q-1]];
      prev_im     = (q == 0) ? 16'hC4DF : EXP_IM[quad[q-1]];
      twiddle_num = 4'(quad[q]);
      #3;
      check_pair($sformatf("quad%0d_before_edge", quad[q]), prev_re, prev_im);
      for (int c = 0; c < 3; c++) begin
        step();
        check_pair($sformatf("quad%0d_c%0d", quad[q], c),
                   EXP_RE[quad[q]], EXP_IM[quad[q]]);
      end
    end

    // Full sweep, one index per cycle.
    for (int k = 0; k < 16; k++) begin
      twiddle_num = 4'(k);
      step();
      check_pair($sformatf("sweep_k%0d", k), EXP_RE[k], EXP_IM[k]);
      check_power($sformatf("power_k%0d", k));
    end

    // Index change while clk is low must wait for the next rising edge.
    twiddle_num = 4'd2;
    step();
    check_pair("midcyc_k2", 16'h2D41, 16'hD2BF);
    @(negedge clk);
    twiddle_num = 4'd14;
    #1;
    check_pair("midcyc_hold", 16'h2D41, 16'hD2BF);
    step();
    check_pair("midcyc_k14", 16'h2D41, 16'h2D41);

    // Sweep interrupted by an asynchronous reset between edges.
    for (int k = 0; k < 4; k++) begin
      twiddle_num = 4'(k);
      step();
      check_pair($sformatf("rsweep_k%0d", k), EXP_RE[k], EXP_IM[k]);
    end
    twiddle_num = 4'd4;
    #2;
    rst = 1'b0;
    #1;
    check_pair("async_reset_clear", 16'h0000, 16'h0000);
    step();
    check_pair("async_reset_hold", 16'h0000, 16'h0000);
    #2;
    rst = 1'b1;
    step();
    check_pair("resume_k4", EXP_RE[4], EXP_IM[4]);
    for (int k = 5; k < 8; k++) begin
      twiddle_num = 4'(k);
      step();
      check_pair($sformatf("resume_k%0d", k), EXP_RE[k], EXP_IM[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
